// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory arbiter.
//   - access size encodings
//   - arbiter/sequencer state enum
//   - sub-word merge and load-extract helpers (32-bit, 4 byte lanes)
// The memory behind the arbiter reads and writes the four bytes starting at
// mem_a (little-endian), so the wanted bytes always sit in the low lanes.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACC,
    ST_RMW_RD,
    ST_RMW_WR,
    ST_DONE
  } state_t;

  // Replace the low byte of the word read back with the store byte.
  function automatic logic [31:0] merge_byte(input logic [31:0] merge,
                                             input logic [31:0] wdata);
    return {merge[31:8], wdata[7:0]};
  endfunction

  // Replace the low halfword of the word read back with the store half.
  function automatic logic [31:0] merge_half(input logic [31:0] merge,
                                             input logic [31:0] wdata);
    return {merge[31:16], wdata[15:0]};
  endfunction

  // Zero-extended load result; size 11 is treated as a full word.
  function automatic logic [31:0] load_extract(input logic [31:0] rd,
                                               input logic [1:0]  size);
    case (size)
      SZ_BYTE: return {24'h0, rd[7:0]};
      SZ_HALF: return {16'h0, rd[15:0]};
      default: return rd;
    endcase
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   CLK  clock
//   RST  synchronous active-high reset (last = 1, so requester 0 wins first)
//   req  request vector, bit n = requester n
//   upd  grant strobe; the pointer moves to the granted id
//   gnt  id of the requester to grant (only meaningful when |req)
module rr_arb2 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       upd,
  output logic       gnt
);

  logic last;

  // Contention goes to whoever was not served last; a lone request wins.
  always_comb begin
    gnt = req[1];
    if (req == 2'b11) begin
      gnt = ~last;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      last <= 1'b1;
    end else if (upd) begin
      last <= gnt;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-cycle data-memory port between the core
// load/store path (m0) and the loader (m1), and turns byte/half stores into
// read-modify-write sequences because the memory writes whole words only.
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   mN_req/we/size      request, 1=store, 00 byte 01 half 10/11 word
//   mN_addr/wdata       byte address, store data (low bytes for sub-word)
//   mN_done             one-cycle completion pulse
//   mN_rdata            zero-extended load result, held until next load
//   mem_a/mem_wd/mem_we memory address, write data, write enable
//   mem_rd              memory read data, combinational from mem_a
//   busy                high whenever the sequencer is not idle
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [1:0]    m0_size,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_done,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [1:0]    m1_size,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_done,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy
);

  state_t        state;
  logic          gnt;
  logic          grant;
  logic          id_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] merge_q;

  logic          sel_we;
  logic [1:0]    sel_size;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_rmw;

  assign grant = (state == ST_IDLE) && (m0_req || m1_req);

  rr_arb2 u_arb (
    .CLK (CLK),
    .RST (RST),
    .req ({m1_req, m0_req}),
    .upd (grant),
    .gnt (gnt)
  );

  // Fields of the requester being granted this cycle.
  always_comb begin
    sel_we    = gnt ? m1_we    : m0_we;
    sel_size  = gnt ? m1_size  : m0_size;
    sel_addr  = gnt ? m1_addr  : m0_addr;
    sel_wdata = gnt ? m1_wdata : m0_wdata;
    sel_rmw   = sel_we && ((sel_size == SZ_BYTE) || (sel_size == SZ_HALF));
  end

  // Control: state, done pulses and load results.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_done <= 1'b0;
      m1_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state <= sel_rmw ? ST_RMW_RD : ST_ACC;
          end
        end
        ST_ACC: begin
          if (!we_q) begin
            if (id_q) m1_rdata <= load_extract(mem_rd, size_q);
            else      m0_rdata <= load_extract(mem_rd, size_q);
          end
          m0_done <= ~id_q;
          m1_done <= id_q;
          state   <= ST_DONE;
        end
        ST_RMW_RD: begin
          state <= ST_RMW_WR;
        end
        ST_RMW_WR: begin
          m0_done <= ~id_q;
          m1_done <= id_q;
          state   <= ST_DONE;
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Datapath latches; only ever used under a non-idle state, so no reset.
  always_ff @(posedge CLK) begin
    if (grant) begin
      id_q    <= gnt;
      we_q    <= sel_we;
      size_q  <= sel_size;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
    end
    if (state == ST_RMW_RD) begin
      merge_q <= mem_rd;
    end
  end

  // Memory pins decode from registered state and latches only, so they are
  // zero in IDLE/DONE and the write strobe cannot glitch on requester inputs.
  always_comb begin
    mem_a  = '0;
    mem_wd = '0;
    mem_we = 1'b0;
    case (state)
      ST_ACC: begin
        mem_a = addr_q;
        if (we_q) begin
          mem_wd = wdata_q;
          mem_we = 1'b1;
        end
      end
      ST_RMW_RD: begin
        mem_a = addr_q;
      end
      ST_RMW_WR: begin
        mem_a  = addr_q;
        mem_we = 1'b1;
        mem_wd = (size_q == SZ_BYTE) ? merge_byte(merge_q, wdata_q)
                                     : merge_half(merge_q, wdata_q);
      end
      default: begin
      end
    endcase
  end

  assign busy = (state != ST_IDLE);

endmodule
